hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 20 ++
 rtl/hazard_ctrl_load_use_detect.sv | 22 ++
 rtl/hazard_ctrl.sv | 103 ++++++++++
 tb/tb_hazard_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: write-data source
// codes, FSM state encoding and the register-match helper.
package hazard_ctrl_pkg;

    localparam logic [1:0]  WDATA_SRC_MEM = 2'd1;
    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MDU_WAIT = 2'd1
    } state_e;

    // Register $zero is never a real producer, so a match on it is ignored.
    function automatic logic reg_match(input logic [4:0] src_addr,
                                       input logic [4:0] dst_addr,
                                       input logic       src_used);
        return src_used && (dst_addr != 5'd0) && (src_addr == dst_addr);
    endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID operand that depends on a load still in EXE.
module load_use_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [1:0] exe_wdata_src_i,
    input  logic [4:0] exe_wr_addr_i,
    input  logic [4:0] id_rs_addr_i,
    input  logic       id_rs_used_i,
    input  logic [4:0] id_rt_addr_i,
    input  logic       id_rt_used_i,
    output logic       load_use_o
);

    logic exe_is_load;

    assign exe_is_load = (exe_wdata_src_i == WDATA_SRC_MEM);

    assign load_use_o = exe_is_load &&
                        (reg_match(id_rs_addr_i, exe_wr_addr_i, id_rs_used_i) ||
                         reg_match(id_rt_addr_i, exe_wr_addr_i, id_rt_used_i));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle MDU occupancy
// stalls, taken-branch IF/ID flush and a saturating stall-cycle counter.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | normal issue; load-use stall, MDU start or branch flush possible
// MDU_WAIT | MDU busy in EXE; front end frozen until mdu_cnt reaches 1
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic        id_is_mdu,
    input  logic        id_branch_taken,
    input  logic [1:0]  exe_WriteDataSrc,
    input  logic [4:0]  exe_reg_write_addr,
    output logic        pause,
    output logic        pc_hold,
    output logic        if_id_hold,
    output logic        if_id_flush,
    output logic [31:0] stall_cycles
);

    localparam logic [2:0] MDU_LOAD = 3'(MDU_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  mdu_cnt_q, mdu_cnt_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic        load_use;
    logic        stall;
    logic        flush;

    load_use_detect u_load_use_detect (
        .exe_wdata_src_i (exe_WriteDataSrc),
        .exe_wr_addr_i   (exe_reg_write_addr),
        .id_rs_addr_i    (id_rs_addr),
        .id_rs_used_i    (id_rs_used),
        .id_rt_addr_i    (id_rt_addr),
        .id_rt_used_i    (id_rt_used),
        .load_use_o      (load_use)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            mdu_cnt_q      <= 3'd0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            mdu_cnt_q      <= mdu_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        stall     = 1'b0;
        flush     = 1'b0;
        case (state_q)
            MDU_WAIT: begin
                stall     = 1'b1;
                mdu_cnt_d = mdu_cnt_q - 3'd1;
                // <= 1 rather than == 1 so a corrupted zero count cannot lock up
                if (mdu_cnt_q <= 3'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (load_use) begin
                    stall = 1'b1;
                end else if (id_is_mdu) begin
                    state_d   = MDU_WAIT;
                    mdu_cnt_d = MDU_LOAD;
                end else if (id_branch_taken) begin
                    flush = 1'b1;
                end
            end
        endcase
    end

    // Outputs are gated by reset so the combinational hazard path is silent too.
    assign pause       = rst & stall;
    assign pc_hold     = rst & stall;
    assign if_id_hold  = rst & stall;
    assign if_id_flush = rst & flush;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (pc_hold && (stall_cycles_q != STALL_CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MEM = WDATA_SRC_MEM;

    typedef struct {
        logic        st;
        logic        fl;
        logic [31:0] cnt;
        int          idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs_addr = '0;
    logic [4:0]  id_rt_addr = '0;
    logic        id_rs_used = 1'b0;
    logic        id_rt_used = 1'b0;
    logic        id_is_mdu = 1'b0;
    logic        id_branch_taken = 1'b0;
    logic [1:0]  exe_WriteDataSrc = '0;
    logic [4:0]  exe_reg_write_addr = '0;
    logic        pause, pc_hold, if_id_hold, if_id_flush;
    logic [31:0] stall_cycles;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_miss = 0;
    bit   done = 1'b0;

    hazard_ctrl #(.MDU_CYCLES(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .id_rs_addr         (id_rs_addr),
        .id_rt_addr         (id_rt_addr),
        .id_rs_used         (id_rs_used),
        .id_rt_used         (id_rt_used),
        .id_is_mdu          (id_is_mdu),
        .id_branch_taken    (id_branch_taken),
        .exe_WriteDataSrc   (exe_WriteDataSrc),
        .exe_reg_write_addr (exe_reg_write_addr),
        .pause              (pause),
        .pc_hold            (pc_hold),
        .if_id_hold         (if_id_hold),
        .if_id_flush        (if_id_flush),
        .stall_cycles       (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic [1:0] ws, input logic [4:0] wa,
                         input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu,
                         input logic mdu, input logic br);
        rst                = r;
        exe_WriteDataSrc   = ws;
        exe_reg_write_addr = wa;
        id_rs_addr         = rs;
        id_rs_used         = rsu;
        id_rt_addr         = rt;
        id_rt_used         = rtu;
        id_is_mdu          = mdu;
        id_branch_taken    = br;
    endtask

    task automatic push(input logic st, input logic fl, input logic [31:0] cnt);
        exp_t e;
        e.st  = st;
        e.fl  = fl;
        e.cnt = cnt;
        e.idx = n_vec;
        exp_q.push_back(e);
        n_vec++;
    endtask

    task automatic vec(input logic r, input logic [1:0] ws, input logic [4:0] wa,
                       input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu,
                       input logic mdu, input logic br,
                       input logic st, input logic fl, input logic [31:0] cnt);
        @(posedge clk);
        #1;
        drive(r, ws, wa, rs, rsu, rt, rtu, mdu, br);
        push(st, fl, cnt);
    endtask

    task automatic cmp1(input string name, input int idx, input logic act, input logic req);
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s vec %0d: got %b want %b", name, idx, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp1("pause",       e.idx, pause,       e.st);
            cmp1("pc_hold",     e.idx, pc_hold,     e.st);
            cmp1("if_id_hold",  e.idx, if_id_hold,  e.st);
            cmp1("if_id_flush", e.idx, if_id_flush, e.fl);
            if (stall_cycles !== e.cnt) begin
                n_miss++;
                $display("FAIL stall_cycles vec %0d: got %h want %h", e.idx, stall_cycles, e.cnt);
            end
        end
    end

    initial begin
        //   rst ws       wa  rs  rsu rt  rtu mdu br   st fl cnt
        vec(0, SRC_MEM, 5,  5,  1,  0,  0,  0,  1,   0, 0, 0);  // reset masks hazard+branch
        vec(1, SRC_ALU, 0,  0,  0,  0,  0,  0,  0,   0, 0, 0);  // idle
        vec(1, SRC_MEM, 5,  5,  1,  0,  0,  0,  0,   1, 0, 0);  // load-use on rs
        vec(1, SRC_ALU, 0,  5,  1,  0,  0,  0,  0,   0, 0, 1);  // bubble clears it
        vec(1, SRC_MEM, 0,  0,  1,  0,  1,  0,  0,   0, 0, 1);  // $zero exempt
        vec(1, SRC_MEM, 7,  3,  1,  7,  0,  0,  0,   0, 0, 1);  // rt match, unused
        vec(1, SRC_MEM, 7,  3,  1,  7,  1,  0,  0,   1, 0, 1);  // rt match, used
        vec(1, SRC_ALU, 7,  7,  1,  0,  0,  0,  0,   0, 0, 2);  // non-load producer
        vec(1, SRC_MEM, 9,  9,  1,  0,  0,  0,  1,   1, 0, 2);  // branch + load-use
        vec(1, SRC_ALU, 0,  0,  0,  0,  0,  0,  1,   0, 1, 3);  // branch alone
        vec(1, SRC_ALU, 0,  0,  0,  0,  0,  0,  0,   0, 0, 3);  // flush lasts one cycle
        vec(1, SRC_ALU, 0,  0,  0,  0,  0,  1,  0,   0, 0, 3);  // MDU start, no stall
        vec(1, SRC_MEM, 4,  4,  1,  4,  1,  1,  1,   1, 0, 3);  // MDU_WAIT ignores inputs
        vec(1, SRC_ALU, 0,  0,  0,  0,  0,  0,  1,   1, 0, 4);
        vec(1, SRC_ALU, 0,  0,  0,  0,  0,  0,  0,   1, 0, 5);
        vec(1, SRC_ALU, 0,  0,  0,  0,  0,  0,  0,   0, 0, 6);  // back in IDLE
        vec(1, SRC_MEM, 4,  4,  1,  0,  0,  1,  0,   1, 0, 6);  // load-use beats MDU start
        vec(1, SRC_ALU, 0,  4,  1,  0,  0,  1,  0,   0, 0, 7);  // MDU start
        vec(1, SRC_ALU, 0,  0,  0,  0,  0,  0,  0,   1, 0, 7);  // one MDU stall cycle
        vec(0, SRC_ALU, 0,  0,  0,  0,  0,  0,  0,   0, 0, 0);  // reset mid-wait
        vec(1, SRC_ALU, 0,  0,  0,  0,  0,  0,  0,   0, 0, 0);  // released into IDLE
        vec(1, SRC_ALU, 0,  0,  0,  0,  0,  0,  1,   0, 1, 0);  // branch honoured

        // Saturation: preload the counter just below its ceiling.
        @(posedge clk);
        #1;
        drive(1, SRC_ALU, 0, 0, 0, 0, 0, 0, 0);
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        push(0, 0, 32'hFFFF_FFFE);
        #1;
        release dut.stall_cycles_q;
        vec(1, SRC_MEM, 6,  6,  1,  0,  0,  0,  0,   1, 0, 32'hFFFF_FFFE);
        vec(1, SRC_MEM, 6,  0,  0,  6,  1,  0,  0,   1, 0, 32'hFFFF_FFFF);
        vec(1, SRC_ALU, 0,  0,  0,  0,  0,  0,  0,   0, 0, 32'hFFFF_FFFF);
        vec(1, SRC_ALU, 0,  0,  0,  0,  0,  0,  0,   0, 0, 32'hFFFF_FFFF);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
